// File: rtl/jh_fdtd_boundary_sequencer_if.sv
// Host/PE-array side bundle of the FDTD boundary sequencer: run control in,
// sweep/write addressing and status out.
interface jh_fdtd_boundary_sequencer_if #(
    parameter int STEP_W = 16
);
    logic              start;
    logic [STEP_W-1:0] num_steps;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              computing_on;
    logic [6:0]        n_addr;
    logic [6:0]        Vn1_addr;
    logic              starting_write;
    logic              finishing_fdtd;
    logic [STEP_W-1:0] step_idx;

    modport master (
        output start, num_steps, abort,
        input  busy, done, aborted, computing_on, n_addr, Vn1_addr,
               starting_write, finishing_fdtd, step_idx
    );

    modport slave (
        input  start, num_steps, abort,
        output busy, done, aborted, computing_on, n_addr, Vn1_addr,
               starting_write, finishing_fdtd, step_idx
    );
endinterface

// File: rtl/jh_fdtd_boundary_sequencer.sv
// Compute-phase controller for one boundary PE: sweeps node read addresses per
// time step and replays them PIPE_LAT cycles later as the write stream.
module jh_fdtd_boundary_sequencer #(
    parameter int NODES    = 108,
    parameter int PIPE_LAT = 3,
    parameter int STEP_W   = 16
) (
    input logic clk,
    input logic rst,
    jh_fdtd_boundary_sequencer_if.slave bus
);
    localparam int AW = 7;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(NODES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWEEP  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [STEP_W-1:0] steps_r;
    logic [STEP_W-1:0] step_idx_r;
    logic [AW-1:0]     n_addr_r;
    logic [DW-1:0]     drain_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              aborted_r;
    logic              computing_on_r;
    logic              finishing_r;

    logic [PIPE_LAT-1:0] pipe_v_r;
    logic [AW-1:0]       pipe_a_r [PIPE_LAT];
    logic [PIPE_LAT-1:0] stage_v_s;
    logic [AW-1:0]       stage_a_s [PIPE_LAT];

    logic start_ok_s;
    logic abort_ok_s;
    logic more_steps_s;
    logic sweep_last_s;
    logic drain_last_s;

    // Next-state decode and run-control qualifiers.
    always_comb begin
        start_ok_s   = (state_r == ST_IDLE) && bus.start;
        abort_ok_s   = bus.abort && (state_r inside {ST_SWEEP, ST_DRAIN, ST_GAP});
        more_steps_s = ({1'b0, step_idx_r} + {{STEP_W{1'b0}}, 1'b1}) < {1'b0, steps_r};
        sweep_last_s = (n_addr_r == LAST_ADDR);
        drain_last_s = (drain_cnt_r == DRAIN_LAST);
        state_s      = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = (bus.num_steps == {STEP_W{1'b0}}) ? ST_DONE : ST_SWEEP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (abort_ok_s) begin
                    state_s = ST_FINISH;
                end else if (sweep_last_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            ST_DRAIN: begin
                if (abort_ok_s) begin
                    state_s = ST_FINISH;
                end else if (drain_last_s) begin
                    state_s = more_steps_s ? ST_GAP : ST_FINISH;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_GAP: begin
                if (abort_ok_s) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            ST_FINISH: state_s = ST_DONE;
            ST_DONE:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters and status outputs, registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            steps_r        <= {STEP_W{1'b0}};
            step_idx_r     <= {STEP_W{1'b0}};
            n_addr_r       <= {AW{1'b0}};
            drain_cnt_r    <= {DW{1'b0}};
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            aborted_r      <= 1'b0;
            computing_on_r <= 1'b0;
            finishing_r    <= 1'b0;
        end else begin
            if (start_ok_s) begin
                steps_r    <= bus.num_steps;
                step_idx_r <= {STEP_W{1'b0}};
                aborted_r  <= 1'b0;
            end else begin
                if (abort_ok_s) begin
                    aborted_r <= 1'b1;
                end
                if ((state_r == ST_GAP) && (state_s == ST_SWEEP) && more_steps_s) begin
                    step_idx_r <= step_idx_r + STEP_W'(1'b1);
                end
            end

            if ((state_r == ST_SWEEP) && (state_s == ST_SWEEP)) begin
                n_addr_r <= n_addr_r + 7'd1;
            end else if ((state_s == ST_SWEEP) || (state_s == ST_GAP)) begin
                n_addr_r <= {AW{1'b0}};
            end else begin
                n_addr_r <= n_addr_r;
            end

            if ((state_r == ST_DRAIN) && (state_s == ST_DRAIN)) begin
                drain_cnt_r <= drain_cnt_r + DW'(1'b1);
            end else begin
                drain_cnt_r <= {DW{1'b0}};
            end

            busy_r         <= (state_s != ST_IDLE);
            done_r         <= (state_s == ST_DONE);
            computing_on_r <= (state_s inside {ST_SWEEP, ST_DRAIN, ST_GAP, ST_FINISH});
            finishing_r    <= (state_s == ST_FINISH);
        end
    end

    // Stage inputs of the write delay line: a new valid enters on every sweep cycle.
    always_comb begin
        stage_v_s[0] = (state_r == ST_SWEEP);
        stage_a_s[0] = n_addr_r;
        for (int i = 1; i < PIPE_LAT; i++) begin
            stage_v_s[i] = pipe_v_r[i-1];
            stage_a_s[i] = pipe_a_r[i-1];
        end
    end

    // Delay line; an address stage only loads with a valid so the tail holds the last write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v_r <= {PIPE_LAT{1'b0}};
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_a_r[i] <= {AW{1'b0}};
            end
        end else if (abort_ok_s) begin
            pipe_v_r <= {PIPE_LAT{1'b0}};
        end else begin
            pipe_v_r <= stage_v_s;
            for (int i = 0; i < PIPE_LAT; i++) begin
                if (stage_v_s[i]) begin
                    pipe_a_r[i] <= stage_a_s[i];
                end else begin
                    pipe_a_r[i] <= pipe_a_r[i];
                end
            end
        end
    end

    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.aborted        = aborted_r;
    assign bus.computing_on   = computing_on_r;
    assign bus.n_addr         = n_addr_r;
    assign bus.Vn1_addr       = pipe_a_r[PIPE_LAT-1];
    assign bus.starting_write = pipe_v_r[PIPE_LAT-1];
    assign bus.finishing_fdtd = finishing_r;
    assign bus.step_idx       = step_idx_r;
endmodule

// File: tb/tb_jh_fdtd_boundary_sequencer.sv
// Self-checking bench: per-cycle comparison against a timeline model of the run,
// directed scenarios pinned with literal cycle counts, then random traffic.
module tb_jh_fdtd_boundary_sequencer;
    localparam int NODES    = 108;
    localparam int PIPE_LAT = 3;
    localparam int STEP_W   = 16;
    localparam int L        = NODES + PIPE_LAT;

    typedef enum int {P_IDLE, P_SWEEP, P_DRAIN, P_GAP, P_FINISH, P_DONE} phase_e;

    logic clk;
    logic rst;

    jh_fdtd_boundary_sequencer_if #(.STEP_W(STEP_W)) bus_if ();

    jh_fdtd_boundary_sequencer #(
        .NODES(NODES), .PIPE_LAT(PIPE_LAT), .STEP_W(STEP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a run is a timeline indexed by r = cycles since the accepted start.
    bit m_active = 0;
    int m_r = 0, m_fin_rel = -1, m_done_rel = -1, m_cut = 0;
    int m_n = 0, m_step = 0, m_vn1 = 0;
    bit m_ab = 0;
    bit e_busy, e_done, e_fin, e_comp, e_wr;

    int since = 0, wr_cnt = 0, done_at = -1, last_wr = -1, ab_at_done = 0;

    function automatic phase_e phase_of(input int r);
        int off;
        if (!m_active) return P_IDLE;
        if (r == m_done_rel) return P_DONE;
        if (r == m_fin_rel) return P_FINISH;
        off = (r - 1) % (L + 1);
        if (off < NODES) return P_SWEEP;
        if (off < L) return P_DRAIN;
        return P_GAP;
    endfunction

    task automatic model_step(input bit r_i, input bit s_i, input int ns_i, input bit a_i);
        phase_e ph;
        int off, j;
        if (r_i) begin
            m_active = 0; m_n = 0; m_step = 0; m_vn1 = 0; m_ab = 0;
        end else if (m_active) begin
            ph = phase_of(m_r);
            if (a_i && (ph == P_SWEEP || ph == P_DRAIN || ph == P_GAP)) begin
                m_fin_rel = m_r + 1; m_done_rel = m_r + 2; m_cut = m_r; m_ab = 1;
            end
            if (ph == P_DONE) m_active = 0;
            else m_r++;
        end else if (s_i) begin
            m_active = 1; m_r = 1; m_ab = 0; m_step = 0; m_cut = 1 << 30;
            if (ns_i == 0) begin
                m_fin_rel = -1; m_done_rel = 1;
            end else begin
                m_fin_rel = ns_i * (L + 1); m_done_rel = m_fin_rel + 1;
            end
        end
        ph  = phase_of(m_r);
        off = (m_r - 1) % (L + 1);
        j   = (m_r - 1) / (L + 1);
        e_busy = (ph != P_IDLE);
        e_done = (ph == P_DONE);
        e_fin  = (ph == P_FINISH);
        e_comp = (ph == P_SWEEP || ph == P_DRAIN || ph == P_GAP || ph == P_FINISH);
        case (ph)
            P_SWEEP: begin m_n = off;       m_step = j; end
            P_DRAIN: begin m_n = NODES - 1; m_step = j; end
            P_GAP:   begin m_n = 0;         m_step = j; end
            default: ;
        endcase
        e_wr = (ph == P_SWEEP || ph == P_DRAIN || ph == P_GAP) && (m_r <= m_cut)
               && (off >= PIPE_LAT) && (off < L);
        if (e_wr) m_vn1 = off - PIPE_LAT;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic compare_all();
        chk("busy",           int'(bus_if.busy),           int'(e_busy));
        chk("done",           int'(bus_if.done),           int'(e_done));
        chk("aborted",        int'(bus_if.aborted),        int'(m_ab));
        chk("computing_on",   int'(bus_if.computing_on),   int'(e_comp));
        chk("finishing_fdtd", int'(bus_if.finishing_fdtd), int'(e_fin));
        chk("starting_write", int'(bus_if.starting_write), int'(e_wr));
        chk("n_addr",         int'(bus_if.n_addr),         m_n);
        chk("Vn1_addr",       int'(bus_if.Vn1_addr),       m_vn1);
        chk("step_idx",       int'(bus_if.step_idx),       m_step);
    endtask

    task automatic tick(input bit r_i, input bit s_i, input int ns_i, input bit a_i);
        bit acc;
        acc = !r_i && s_i && !m_active;
        rst              = r_i;
        bus_if.start     = s_i;
        bus_if.num_steps = STEP_W'(ns_i);
        bus_if.abort     = a_i;
        @(posedge clk);
        model_step(r_i, s_i, ns_i, a_i);
        @(negedge clk);
        if (acc) begin
            since = 1; wr_cnt = 0; done_at = -1; last_wr = -1;
        end else begin
            since++;
        end
        compare_all();
        if (bus_if.starting_write) begin
            wr_cnt++;
            last_wr = int'(bus_if.Vn1_addr);
        end
        if (bus_if.done) begin
            done_at    = since;
            ab_at_done = int'(bus_if.aborted);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.num_steps = '0;
        bus_if.abort = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 0, 1'b0);
        idle(2);

        // single step with an ignored start (num_steps=9) on cycle 30
        tick(1'b0, 1'b1, 1, 1'b0);
        idle(29);
        tick(1'b0, 1'b1, 9, 1'b0);
        idle(89);
        chk("single_done_cycle", done_at, 113);
        chk("single_writes", wr_cnt, 108);
        chk("single_last_vn1", last_wr, 107);

        // two steps
        tick(1'b0, 1'b1, 2, 1'b0);
        idle(230);
        chk("two_done_cycle", done_at, 225);
        chk("two_writes", wr_cnt, 216);

        // zero steps
        tick(1'b0, 1'b1, 0, 1'b0);
        idle(5);
        chk("zero_done_cycle", done_at, 1);
        chk("zero_writes", wr_cnt, 0);

        // abort mid-sweep on cycle 50
        tick(1'b0, 1'b1, 5, 1'b0);
        idle(49);
        tick(1'b0, 1'b0, 0, 1'b1);
        idle(10);
        chk("abort_done_cycle", done_at, 52);
        chk("abort_flag", ab_at_done, 1);
        chk("abort_last_vn1", last_wr, 46);
        chk("abort_writes", wr_cnt, 47);

        // abort on the final drain cycle
        tick(1'b0, 1'b1, 1, 1'b0);
        idle(110);
        tick(1'b0, 1'b0, 0, 1'b1);
        idle(6);
        chk("abort_drain_done_cycle", done_at, 113);
        chk("abort_drain_flag", ab_at_done, 1);
        chk("abort_drain_writes", wr_cnt, 108);

        // reset on cycle 60, restart on cycle 62
        tick(1'b0, 1'b1, 1, 1'b0);
        idle(59);
        tick(1'b1, 1'b0, 0, 1'b0);
        chk("rst_busy", int'(bus_if.busy), 0);
        chk("rst_n_addr", int'(bus_if.n_addr), 0);
        idle(1);
        tick(1'b0, 1'b1, 1, 1'b0);
        idle(120);
        chk("rst_restart_done_cycle", done_at, 113);
        chk("rst_restart_writes", wr_cnt, 108);

        // random traffic
        for (int k = 0; k < 20000; k++) begin
            tick(($urandom % 3000) == 0, ($urandom % 25) == 0,
                 int'($urandom % 4), ($urandom % 300) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jh_fdtd_boundary_sequencer.md
Name: jh_fdtd_boundary_sequencer

Overview:
- Controller that drives one boundary PE of the FDTD array through its compute phase.
- Generates the computing_on window, the read-address sweep n_addr, the delayed write-address stream Vn1_addr, the write strobe starting_write and the terminating finishing_fdtd flag.
- Runs for a host-specified number of time steps, then returns the PE to host-load mode.
- Sits between the host/HPS control registers and the PE array; its outputs fan out to all PEs.

Parameters:
- NODES, 108, nodes per PE sweep; n_addr and Vn1_addr span 0..NODES-1 (NODES <= 128).
- PIPE_LAT, 3, cycles from n_addr issue to the matching Vn1/Vn1_addr being valid at the PE (>= 1).
- STEP_W, 16, width of the step counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- num_steps  in  STEP_W  time steps to run; sampled on the accepted start.
- abort  in  1  terminates an active run early.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run (normal or aborted).
- aborted  out  1  high with done when the run ended by abort.
- computing_on  out  1  selects compute-mode muxing in the PEs.
- n_addr  out  7  node read address.
- Vn1_addr  out  7  write address for the new voltage, equal to n_addr delayed PIPE_LAT cycles.
- starting_write  out  1  high on exactly the cycles where Vn1_addr carries a valid write.
- finishing_fdtd  out  1  high for the single FINISH cycle; blocks PE writes.
- step_idx  out  STEP_W  index of the current step, starting at 0.

Behaviour:
- Reset (rst=1 at a clock edge, in any state, including mid-sweep):
  - state goes to IDLE.
  - All outputs go to 0, including n_addr, Vn1_addr, step_idx, aborted and the valid delay line.
- States: IDLE, SWEEP, DRAIN, GAP, FINISH, DONE.
- IDLE:
  - computing_on=0, busy=0.
  - On start: latch num_steps as S and clear step_idx.
  - If S==0, go directly to DONE (no sweep, finishing_fdtd stays 0). Otherwise go to SWEEP with n_addr=0.
- SWEEP:
  - computing_on=1; n_addr increments by 1 each cycle from 0 to NODES-1.
  - After NODES cycles, go to DRAIN.
- DRAIN:
  - Lasts PIPE_LAT cycles; n_addr holds NODES-1 and issues no new valid.
  - Exit: if step_idx+1 < S, go to GAP; otherwise go to FINISH.
- GAP:
  - Lasts 1 cycle; step_idx increments by 1 and n_addr resets to 0.
  - Next state is SWEEP.
  - GAP gives the PEs one cycle to settle before the next step reads new data.
- FINISH: 1 cycle; finishing_fdtd=1, computing_on=1, starting_write=0. Next state is DONE.
- DONE: 1 cycle; done=1, computing_on=0, finishing_fdtd=0. Next state is IDLE.
- Write pipeline:
  - A PIPE_LAT-deep shift register carries (valid, addr).
  - valid=1 is inserted on each SWEEP cycle; Vn1_addr and starting_write are taken from the tail.
  - starting_write is high for exactly NODES cycles per step, with Vn1_addr = 0..NODES-1 in order.
  - Outside valid cycles, Vn1_addr holds its last value.
- Cycle count for S steps, from the start cycle to done: S*(NODES+PIPE_LAT) + (S-1) + 2.
- Counters:
  - n_addr never wraps past NODES-1.
  - step_idx saturates at S-1.
  - Comparisons are unsigned.
- Start handling: start while busy is ignored, with no latch update and no restart.
- Abort:
  - When abort=1 in SWEEP, DRAIN or GAP, the next state is FINISH.
  - The delay line is cleared immediately, so no further starting_write occurs.
  - aborted=1 is set and held through DONE; it clears on the next accepted start or on rst.
  - Abort in IDLE, FINISH or DONE has no effect.
- Simultaneous events: abort and the final DRAIN cycle together → FINISH with aborted=1 and no extra write. rst has priority over everything.

Test Plan:
- Single step (NODES=108, PIPE_LAT=3): start at cycle 0 with num_steps=1.
  - computing_on=1 on cycles 1..112.
  - n_addr counts 0..107 on cycles 1..108.
  - starting_write high on cycles 4..111 with Vn1_addr 0..107.
  - finishing_fdtd on cycle 112; done on cycle 113; busy=0 on cycle 114.
- Two steps: num_steps=2.
  - GAP on cycle 112, with step_idx=1 from cycle 113.
  - Second sweep on cycles 113..220, writes on 116..223.
  - finishing_fdtd on cycle 224; done on cycle 225; exactly 216 write strobes in total.
- Zero steps: start with num_steps=0.
  - done on cycle 1.
  - computing_on, starting_write and finishing_fdtd never assert.
- Abort: num_steps=5, abort on cycle 50 (SWEEP, n_addr=49).
  - FINISH on cycle 51; done with aborted=1 on cycle 52.
  - No starting_write after cycle 50 (last Vn1_addr=46).
- Reset mid-run: rst on cycle 60 of a run.
  - On cycle 61 every output is 0 and state is IDLE.
  - A new start on cycle 62 reproduces the single-step timing, offset by 62.
- Start while busy: a second start with num_steps=9 on cycle 30 of a 1-step run is ignored; the run still completes with done on cycle 113.
